// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequenced 3-to-8 decoder.
// Build option DECODER_ACTIVE_LOW_EN: when defined, out is active-low one-hot (idle 8'hFF).
// No logic here; decode_line gives the driven pattern for a selected code.
package decoder_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 8;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] OUT_IDLE = 8'hFF;
`else
    localparam logic [OUT_W-1:0] OUT_IDLE = 8'h00;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Output pattern while a code is being driven, in the configured polarity
    function automatic logic [OUT_W-1:0] decode_line(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] v;
        v = OUT_W'(1) << code;
`ifdef DECODER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable 8-bit down-counter shared by the PULSE and GAP phases.
// Latency: count updates one cycle after load/en; o_nxt_zero looks one cycle ahead.
// Backpressure: none; load has priority over en, counting saturates at zero.
module pulse_timer
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero,
    output logic             o_nxt_zero
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: reset clears, load wins over decrement, hold at zero
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!rst_n)
            w_cnt_nxt = '0;
        else if (i_load)
            w_cnt_nxt = i_load_val;
        else if (i_en && (r_cnt != '0))
            w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk) begin
        r_cnt <= w_cnt_nxt;
    end

    assign o_zero     = (r_cnt == '0);
    assign o_nxt_zero = (w_cnt_nxt == '0);

endmodule

// File: rtl/decoder_pulse_seq.sv
// Sequenced 3-to-8 decoder: accepted code drives one out line for PULSE_LEN cycles, then GAP_LEN idle cycles.
// Latency: out valid the cycle after the accepting edge; out/busy/done are flops. Option: DECODER_ACTIVE_LOW_EN.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, so senders must hold it.
module decoder_pulse_seq
    import decoder_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    // GAP_LEN==0 never loads the timer for a gap, so the zero load value is unused
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic              w_accept;
    logic              w_zero;
    logic              w_nxt_zero;
    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_val;
    logic              w_tmr_en;
    logic [OUT_W-1:0]  w_out_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [OUT_W-1:0]  r_out;
    logic              r_busy;
    logic              r_done;

    assign in_ready = (r_state == IDLE) && rst_n;
    assign w_accept = in_valid && in_ready;

    pulse_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_zero),
        .o_nxt_zero (w_nxt_zero)
    );

    // State, code and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_out   <= OUT_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and timer control
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_tmr_load  = 1'b0;
        w_tmr_val   = PULSE_LOAD;
        w_tmr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = PULSE;
                    w_code_nxt  = in;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = PULSE_LOAD;
                end
            end
            PULSE: begin
                w_tmr_en = 1'b1;
                if (w_zero) begin
                    if (GAP_LEN == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = GAP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                w_tmr_en = 1'b1;
                if (w_zero)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode one cycle ahead so the flops line up with the state they describe
    always_comb begin
        w_out_nxt  = OUT_IDLE;
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = 1'b0;
        if (w_state_nxt == PULSE) begin
            w_out_nxt  = decode_line(w_code_nxt);
            w_done_nxt = w_nxt_zero;
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_decoder_pulse_seq.sv
// Directed bench for decoder_pulse_seq: default timing instance plus a PULSE_LEN=1/GAP_LEN=0 instance.
// Expected patterns follow the polarity chosen by DECODER_ACTIVE_LOW_EN.
// All checks sample 1 time unit after the rising edge.
module tb_decoder_pulse_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_a;
    logic       vld_a;
    logic       rdy_a;
    logic [7:0] out_a;
    logic       busy_a;
    logic       done_a;
    logic [2:0] in_b;
    logic       vld_b;
    logic       rdy_b;
    logic [7:0] out_b;
    logic       busy_b;
    logic       done_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] IDLE_V = 8'hFF;
`else
    localparam logic [7:0] IDLE_V = 8'h00;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decoder_pulse_seq #(.PULSE_LEN(4), .GAP_LEN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(in_a), .in_valid(vld_a), .in_ready(rdy_a),
        .out(out_a), .busy(busy_a), .done(done_a)
    );

    decoder_pulse_seq #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in_b), .in_valid(vld_b), .in_ready(rdy_b),
        .out(out_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [7:0] pat(input int code);
        logic [7:0] v;
        v = 8'd1 << code;
`ifdef DECODER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    function automatic int ones(input logic [7:0] v);
`ifdef DECODER_ACTIVE_LOW_EN
        return $countones(~v);
`else
        return $countones(v);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until dut_a is ready; returns 0 on timeout
    task automatic wait_ready_a(output bit ok);
        int n;
        n = 0;
        while (!rdy_a && n < 20) begin
            tick();
            n++;
        end
        ok = rdy_a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld_a = 1'b1; in_a = 3'd5; vld_b = 1'b1; in_b = 3'd5;
        repeat (3) tick();
        checks++; if (out_a !== IDLE_V) begin errors++; $display("FAIL reset_out got=%h exp=%h", out_a, IDLE_V); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", rdy_a); end
        checks++; if (out_b !== IDLE_V) begin errors++; $display("FAIL reset_out_b got=%h exp=%h", out_b, IDLE_V); end
        vld_a = 1'b0; vld_b = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", rdy_a); end
        tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL release_busy got=%b exp=0", busy_a); end
        checks++; if (out_a !== IDLE_V) begin errors++; $display("FAIL release_out got=%h exp=%h", out_a, IDLE_V); end
    endtask

    task automatic test_single();
        in_a = 3'd6; vld_a = 1'b1;
        tick();
        vld_a = 1'b0; in_a = 3'd0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_a !== pat(6)) begin errors++; $display("FAIL single_out[%0d] got=%h exp=%h", i, out_a, pat(6)); end
            checks++; if (done_a !== (i == 3)) begin errors++; $display("FAIL single_done[%0d] got=%b exp=%b", i, done_a, (i == 3)); end
            checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy[%0d] got=%b exp=1", i, busy_a); end
            tick();
        end
        checks++; if (out_a !== IDLE_V) begin errors++; $display("FAIL gap_out got=%h exp=%h", out_a, IDLE_V); end
        checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL gap_flags busy=%b done=%b exp busy=1 done=0", busy_a, done_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL gap_ready got=%b exp=0", rdy_a); end
        tick();
        checks++; if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL after_gap ready=%b busy=%b exp ready=1 busy=0", rdy_a, busy_a); end
    endtask

    task automatic test_all_codes();
        int  t_prev;
        bit  ok;
        t_prev = 0;
        vld_a = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_a = 3'(c);
            wait_ready_a(ok);
            if (!ok) begin
                checks++; errors++; $display("FAIL sweep_timeout code=%0d ready=%b exp=1", c, rdy_a);
            end
            tick();
            if (c > 0) begin
                checks++; if (cyc - t_prev !== 6) begin errors++; $display("FAIL sweep_spacing code=%0d got=%0d exp=6", c, cyc - t_prev); end
            end
            t_prev = cyc;
            for (int k = 0; k < 4; k++) begin
                checks++; if (out_a !== pat(c)) begin errors++; $display("FAIL sweep_out code=%0d k=%0d got=%h exp=%h", c, k, out_a, pat(c)); end
                if (k < 3) tick();
            end
            checks++; if (ones(out_a) !== 1) begin errors++; $display("FAIL sweep_onehot code=%0d got=%0d exp=1", c, ones(out_a)); end
        end
        vld_a = 1'b0;
        tick(); tick();
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL sweep_drain ready=%b exp=1", rdy_a); end
    endtask

    task automatic test_busy_ignore();
        int t0;
        bit ok;
        in_a = 3'd2; vld_a = 1'b1;
        tick();
        t0 = cyc;
        in_a = 3'd7;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_a !== pat(2)) begin errors++; $display("FAIL busy_hold k=%0d got=%h exp=%h", k, out_a, pat(2)); end
            tick();
        end
        wait_ready_a(ok);
        if (!ok) begin
            checks++; errors++; $display("FAIL busy_timeout ready=%b exp=1", rdy_a);
        end
        tick();
        vld_a = 1'b0;
        checks++; if (cyc - t0 !== 6) begin errors++; $display("FAIL busy_accept_time got=%0d exp=6", cyc - t0); end
        checks++; if (out_a !== pat(7)) begin errors++; $display("FAIL busy_second got=%h exp=%h", out_a, pat(7)); end
        repeat (5) tick();
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL busy_drain ready=%b exp=1", rdy_a); end
    endtask

    task automatic test_short();
        in_b = 3'd1; vld_b = 1'b1;
        tick();
        vld_b = 1'b0;
        checks++; if (out_b !== pat(1)) begin errors++; $display("FAIL short_out got=%h exp=%h", out_b, pat(1)); end
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL short_done got=%b exp=1", done_b); end
        checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL short_ready_busy got=%b exp=0", rdy_b); end
        tick();
        checks++; if (rdy_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL short_after ready=%b busy=%b exp ready=1 busy=0", rdy_b, busy_b); end
        checks++; if (out_b !== IDLE_V || done_b !== 1'b0) begin errors++; $display("FAIL short_idle out=%h done=%b exp out=%h done=0", out_b, done_b, IDLE_V); end
    endtask

    task automatic test_mid_reset();
        in_a = 3'd4; vld_a = 1'b1;
        tick();
        vld_a = 1'b0;
        tick();
        checks++; if (out_a !== pat(4)) begin errors++; $display("FAIL mid_pulse got=%h exp=%h", out_a, pat(4)); end
        rst_n = 1'b0;
        tick();
        checks++; if (out_a !== IDLE_V) begin errors++; $display("FAIL mid_rst_out got=%h exp=%h", out_a, IDLE_V); end
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL mid_rst_flags busy=%b done=%b exp 0 0", busy_a, done_a); end
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL mid_rst_after busy=%b done=%b exp 0 0", busy_a, done_a); end
    endtask

    initial begin
        rst_n = 1'b0; in_a = '0; vld_a = 1'b0; in_b = '0; vld_b = 1'b0;
        #1;
        test_reset();
        test_single();
        test_all_codes();
        test_busy_ignore();
        test_short();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_pulse_seq.md
Name: decoder_pulse_seq

Overview:
- Sequenced 3-to-8 decoder. Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line of an 8-bit output for a fixed number of cycles.
- After the pulse it waits a fixed idle gap, then accepts the next code.
- It is the counterpart of the 8-to-3 priority encoder: it turns codes back into select/strobe lines, for example for LED or peripheral-enable fan-out.

Parameters:
- PULSE_LEN, 4, cycles the one-hot output is held; legal range 1..255.
- GAP_LEN, 1, idle cycles after each pulse before in_ready rises again; legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in  input  3  code to decode; sampled only on accept.
- in_valid  input  1  code present on in.
- in_ready  output  1  block can accept a code.
- out  output  8  one-hot decoded output; all zero when idle.
- busy  output  1  high in PULSE or GAP.
- done  output  1  one-cycle strobe on the last PULSE cycle.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values (rst_n low at a rising edge): state IDLE, out=8'h00, busy=0, done=0, counter=0, code register=0.
- in_ready is forced to 0 whenever rst_n is low.
- State machine has three states: IDLE, PULSE, GAP.
- in_ready = (state==IDLE) && rst_n. It is combinational from state only and never depends on in_valid.
- Accept: in_valid && in_ready at a rising edge. On accept:
  - code register <= in
  - state <= PULSE
  - counter <= PULSE_LEN-1
- Latency: out shows the decoded line in the first cycle after the accepting edge.
- PULSE state:
  - out = 8'b1 << code register, exactly one bit set (code 0 sets bit 0, code 7 sets bit 7).
  - busy=1.
  - Counter decrements each cycle.
  - When counter==0: done=1 for that cycle. Next state is GAP with counter <= GAP_LEN-1, or IDLE directly if GAP_LEN==0.
  - Total time in PULSE is exactly PULSE_LEN cycles.
- GAP state: out=0, busy=1, done=0. Counter decrements; at counter==0 the next state is IDLE. Total time in GAP is GAP_LEN cycles.
- Back-to-back throughput: one code per PULSE_LEN+GAP_LEN+1 cycles.
- in_valid while busy: ignored. Nothing is latched, and no code is lost provided the sender holds in_valid until in_ready is high.
- in is captured only at the accept edge. Changes on in during PULSE do not affect out.
- Registering: out, busy and done are all registered (decoded from registered state, code and counter), so there are no glitches.
- Reset mid-PULSE or mid-GAP: the next edge returns to IDLE, out clears, and done is not emitted.
- Counter width is 8 bits. The PULSE_LEN-1 and GAP_LEN-1 computations never underflow because the GAP_LEN==0 path bypasses GAP.

Optional Feature:
- Macro: DECODER_ACTIVE_LOW_EN.
- Defined: out is active-low one-hot. Idle and reset value is 8'hFF, and the selected bit is 0 during PULSE. All other timing and signals are unchanged.
- Not defined: active-high as described above, idle value 8'h00.

Decomposition:
- Package decoder_pkg holds:
  - state typedef enum {IDLE, PULSE, GAP}
  - CODE_W=3
  - OUT_W=8
  - CNT_W=8
  - OUT_IDLE constant, selected by the macro
- Sub-module pulse_timer: 8-bit loadable down-counter with load, load_val, en and zero flag, using the same clk/rst_n. It is reused for both PULSE and GAP.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, in=5 -> out=8'h00, busy=0, done=0, in_ready=0. After release, in_ready=1 and nothing is accepted during reset.
- Single code, defaults: in=3'd6 accepted at edge N -> out=8'h40 for cycles N+1..N+4, done high only in cycle N+4, out=0 and busy=1 in cycle N+5, in_ready=1 in cycle N+6.
- All codes: sweep in=0..7 back to back with in_valid held high -> out = 01,02,04,...,80 in order, each 4 cycles, spaced 6 cycles apart, exactly one bit set.
- Busy ignore: accept in=2, then change in to 7 with in_valid high during PULSE -> out stays 8'h04, and 7 is accepted only after in_ready rises.
- GAP_LEN=0, PULSE_LEN=1: in=1 -> out=8'h02 with done high in the same single cycle, in_ready=1 the next cycle.
- Mid-operation reset: rst_n=0 in the second PULSE cycle of in=4 -> next cycle out=0, busy=0, no done. Repeat with DECODER_ACTIVE_LOW_EN defined, expecting idle out=8'hFF and pulse 8'hEF.
